// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Bundles the request handshake of the load/store unit and its
//               word-wide data memory port.
//               slave  - seen by load_store_unit
//               master - seen by the pipeline/memory environment
//               Request : start, op, size, unsigned_ld, addr, store_data
//               Status  : busy, done, fault, load_data
//               Memory  : mem_read, mem_write, mem_address, mem_write_data,
//                         mem_read_data
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] load_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  start, op, size, unsigned_ld, addr, store_data, mem_read_data,
        output busy, done, fault, load_data,
        output mem_read, mem_write, mem_address, mem_write_data
    );

    modport master (
        output start, op, size, unsigned_ld, addr, store_data, mem_read_data,
        input  busy, done, fault, load_data,
        input  mem_read, mem_write, mem_address, mem_write_data
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-stage sequencer in front of a word-only data memory.
//               Provides byte/half/word loads with sign or zero extension,
//               sub-word stores via read-modify-write, alignment fault
//               detection and a start/busy/done handshake.
//               Optional feature macro: LSU_RANGE_CHECK_EN - when defined,
//               addresses at or beyond MEM_WORDS*4 bytes fault.
// Ports       : clk   - clock, all state changes on posedge
//               reset - synchronous, active-high
//               bus   - load_store_unit_if.slave (request + memory port)
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  wire logic          clk,
    input  wire logic          reset,
    load_store_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WRITE     = 3'd2,
        S_RMW_READ  = 3'd3,
        S_RMW_WRITE = 3'd4,
        S_DONE      = 3'd5,
        S_ERR       = 3'd6
    } state_t;

    localparam logic [1:0] c_OP_NONE  = 2'b00;
    localparam logic [1:0] c_OP_LOAD  = 2'b01;
    localparam logic [1:0] c_OP_RSVD  = 2'b11;
    localparam logic [1:0] c_SZ_BYTE  = 2'b00;
    localparam logic [1:0] c_SZ_HALF  = 2'b01;
    localparam logic [1:0] c_SZ_WORD  = 2'b10;
    localparam logic [1:0] c_SZ_RSVD  = 2'b11;
    localparam logic [32:0] c_ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_store_data;
    logic [31:0] r_merge;
    logic [31:0] r_load_data;

    logic        w_accept;
    logic        w_fault;
    logic        w_out_of_range;
    logic        w_range_fault;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic [31:0] w_merge;

    // ------------------------------------------------------------------------
    // Request acceptance and fault classification (inputs valid only here)
    // ------------------------------------------------------------------------
    assign w_accept       = (r_state == S_IDLE) && bus.start && (bus.op != c_OP_NONE);
    assign w_out_of_range = ({1'b0, bus.addr} >= c_ADDR_LIMIT);

`ifdef LSU_RANGE_CHECK_EN
    assign w_range_fault = w_out_of_range;
`else
    // Without the range check the memory simply aliases high addresses.
    logic w_unused_range;
    assign w_unused_range = w_out_of_range;
    assign w_range_fault  = 1'b0;
`endif

    assign w_fault = (bus.op == c_OP_RSVD) || (bus.size == c_SZ_RSVD)
                  || ((bus.size == c_SZ_HALF) && bus.addr[0])
                  || ((bus.size == c_SZ_WORD) && (bus.addr[1:0] != 2'b00))
                  || w_range_fault;

    // ------------------------------------------------------------------------
    // Lane extraction for loads and lane merge for sub-word stores
    // ------------------------------------------------------------------------
    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'd0:    w_byte = bus.mem_read_data[7:0];
            2'd1:    w_byte = bus.mem_read_data[15:8];
            2'd2:    w_byte = bus.mem_read_data[23:16];
            default: w_byte = bus.mem_read_data[31:24];
        endcase
        w_half = r_addr[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];

        w_ext = bus.mem_read_data;
        if (r_size == c_SZ_BYTE) begin
            w_ext = r_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
        end else if (r_size == c_SZ_HALF) begin
            w_ext = r_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
        end

        w_merge = bus.mem_read_data;
        if (r_size == c_SZ_BYTE) begin
            case (r_addr[1:0])
                2'd0:    w_merge[7:0]   = r_store_data[7:0];
                2'd1:    w_merge[15:8]  = r_store_data[7:0];
                2'd2:    w_merge[23:16] = r_store_data[7:0];
                default: w_merge[31:24] = r_store_data[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merge[31:16] = r_store_data[15:0];
        end else begin
            w_merge[15:0]  = r_store_data[15:0];
        end
    end

    // ------------------------------------------------------------------------
    // State machine: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // State machine: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_fault)                    w_next_state = S_ERR;
                    else if (bus.op == c_OP_LOAD)   w_next_state = S_LOAD;
                    else if (bus.size == c_SZ_WORD) w_next_state = S_WRITE;
                    else                            w_next_state = S_RMW_READ;
                end
            end
            S_LOAD:      w_next_state = S_DONE;
            S_WRITE:     w_next_state = S_DONE;
            S_RMW_READ:  w_next_state = S_RMW_WRITE;
            S_RMW_WRITE: w_next_state = S_DONE;
            S_DONE:      w_next_state = S_IDLE;
            S_ERR:       w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= 32'h0;
            r_store_data <= 32'h0;
            r_merge      <= 32'h0;
            r_load_data  <= 32'h0;
        end else begin
            if (w_accept) begin
                r_size       <= bus.size;
                r_unsigned   <= bus.unsigned_ld;
                r_addr       <= bus.addr;
                r_store_data <= bus.store_data;
            end
            if (r_state == S_LOAD) begin
                r_load_data <= w_ext;
            end
            if (r_state == S_RMW_READ) begin
                r_merge <= w_merge;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: pure decodes of the current state
    // ------------------------------------------------------------------------
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE) || (r_state == S_ERR);
    assign bus.fault       = (r_state == S_ERR);
    assign bus.load_data   = r_load_data;
    assign bus.mem_read    = (r_state == S_LOAD)  || (r_state == S_RMW_READ);
    assign bus.mem_write   = (r_state == S_WRITE) || (r_state == S_RMW_WRITE);
    assign bus.mem_address = {r_addr[31:2], 2'b00};

    always_comb begin
        bus.mem_write_data = 32'h0;
        if (r_state == S_WRITE) begin
            bus.mem_write_data = r_store_data;
        end else if (r_state == S_RMW_WRITE) begin
            bus.mem_write_data = r_merge;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. Hosts a 1024-word
//               data memory, keeps an independent reference memory and
//               load_data model, and scores each operation on completion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic clk;
    logic reset;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(1024)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory attached to the DUT
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_address[11:2]] <= bus.mem_write_data;
    end
    assign bus.mem_read_data = bus.mem_read ? mem[bus.mem_address[11:2]] : 32'h0;

    // Reference model state
    logic [31:0] ref_mem [0:1023];
    logic [31:0] m_ld;

    typedef struct {
        logic        fault;
        int          lat;
        logic [31:0] ld;
        int          rd;
        int          wr;
        logic [31:0] maddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Builds the expected result of one request and updates the model.
    function automatic exp_t model(input logic [1:0] op, input logic [1:0] size,
                                   input logic uns, input logic [31:0] a,
                                   input logic [31:0] sd);
        exp_t e;
        logic flt;
        logic [31:0] word, lane, mask, ins;
        flt = (op == 2'b11) || (size == 2'b11)
           || (size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00);
`ifdef LSU_RANGE_CHECK_EN
        if (a >= 32'd4096) flt = 1'b1;
`endif
        e.fault = flt;
        e.maddr = {a[31:2], 2'b00};
        e.wdata = 32'h0;
        e.rd = 0;
        e.wr = 0;
        word = ref_mem[a[11:2]];
        if (flt) begin
            e.lat = 1;
        end else if (op == 2'b01) begin
            e.lat = 2;
            e.rd  = 1;
            lane  = word >> (8 * a[1:0]);
            if (size == 2'b00)      m_ld = uns ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            else if (size == 2'b01) m_ld = uns ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            else                    m_ld = word;
        end else if (size == 2'b10) begin
            e.lat = 2;
            e.wr  = 1;
            e.wdata = sd;
            ref_mem[a[11:2]] = sd;
        end else begin
            e.lat = 3;
            e.rd  = 1;
            e.wr  = 1;
            mask = (size == 2'b00) ? 32'h000000FF : 32'h0000FFFF;
            ins  = sd & mask;
            e.wdata = (word & ~(mask << (8 * a[1:0]))) | (ins << (8 * a[1:0]));
            ref_mem[a[11:2]] = e.wdata;
        end
        e.ld = m_ld;
        return e;
    endfunction

    // Issues one request, then watches the DUT until done and scores it.
    task automatic run_op(input string name, input logic [1:0] op, input logic [1:0] size,
                          input logic uns, input logic [31:0] a, input logic [31:0] sd,
                          input bit keep_start);
        exp_t e;
        int rd, wr, lat;
        sb.push_back(model(op, size, uns, a, sd));
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.size = size;
        bus.unsigned_ld = uns; bus.addr = a; bus.store_data = sd;
        @(posedge clk);
        #1;
        // Inputs are don't-care after acceptance
        bus.addr = $urandom; bus.store_data = $urandom; bus.size = 2'($urandom);
        if (keep_start) bus.op = 2'b01;
        else            bus.start = 1'b0;
        rd = 0; wr = 0; lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.mem_read) begin
                rd++;
                check({name, " rd_addr"}, bus.mem_address, sb[0].maddr);
            end
            if (bus.mem_write) begin
                wr++;
                check({name, " wr_addr"}, bus.mem_address, sb[0].maddr);
                check({name, " wr_data"}, bus.mem_write_data, sb[0].wdata);
            end
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        check({name, " latency"}, 32'(lat), 32'(e.lat));
        check({name, " fault"}, 32'(bus.fault), 32'(e.fault));
        check({name, " load_data"}, bus.load_data, e.ld);
        check({name, " reads"}, 32'(rd), 32'(e.rd));
        check({name, " writes"}, 32'(wr), 32'(e.wr));
        if (keep_start) begin
            // The start held during busy must not produce a second operation
            lat = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (bus.done || bus.mem_read || bus.mem_write) lat++;
            end
            check({name, " ignored_start"}, 32'(lat), 32'd0);
        end
    endtask

    initial begin
        int ev;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        m_ld = 32'h0;
        bus.start = 1'b0; bus.op = 2'b00; bus.size = 2'b00;
        bus.unsigned_ld = 1'b0; bus.addr = 32'h0; bus.store_data = 32'h0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst strobes", {30'h0, bus.mem_read, bus.mem_write}, 32'd0);
        check("rst load_data", bus.load_data, 32'h0);
        reset = 1'b0;

        run_op("sw0",    2'b10, 2'b10, 1'b0, 32'h0000_0000, 32'h1234_5678, 1'b0);
        run_op("sw10",   2'b10, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        run_op("lw10",   2'b01, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         1'b0);
        run_op("sb11",   2'b10, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_0080, 1'b0);
        run_op("lb11",   2'b01, 2'b00, 1'b0, 32'h0000_0011, 32'h0,         1'b0);
        run_op("lbu11",  2'b01, 2'b00, 1'b1, 32'h0000_0011, 32'h0,         1'b0);
        run_op("lh12",   2'b01, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         1'b0);
        run_op("lhu12",  2'b01, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         1'b0);
        run_op("lh10",   2'b01, 2'b01, 1'b0, 32'h0000_0010, 32'h0,         1'b0);
        run_op("lw13",   2'b01, 2'b10, 1'b0, 32'h0000_0013, 32'h0,         1'b0);
        run_op("sh11",   2'b10, 2'b01, 1'b0, 32'h0000_0011, 32'h0000_5555, 1'b0);
        run_op("op11",   2'b11, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         1'b0);
        run_op("sz11",   2'b01, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         1'b0);
        run_op("sb17",   2'b10, 2'b00, 1'b0, 32'h0000_0017, 32'hFFFF_FF3C, 1'b0);
        run_op("sh16",   2'b10, 2'b01, 1'b0, 32'h0000_0016, 32'h1234_9ABC, 1'b0);
        run_op("lw14",   2'b01, 2'b10, 1'b0, 32'h0000_0014, 32'h0,         1'b1);

        // Abandon a sub-word store with reset during its read phase
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.size = 2'b01;
        bus.addr = 32'h0000_0010; bus.store_data = 32'h0000_AAAA;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("rmw_rd busy", 32'(bus.busy), 32'd1);
        check("rmw_rd strobe", 32'(bus.mem_read), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_ld = 32'h0;
        ev = 0;
        @(negedge clk);
        check("abort busy", 32'(bus.busy), 32'd0);
        for (int c = 0; c < 4; c++) begin
            if (bus.mem_write || bus.done) ev++;
            @(negedge clk);
        end
        check("abort no write/done", 32'(ev), 32'd0);
        run_op("lw10b",  2'b01, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         1'b0);
        run_op("lw1000", 2'b01, 2'b10, 1'b0, 32'h0000_1000, 32'h0,         1'b0);
        run_op("lbu1003",2'b01, 2'b00, 1'b1, 32'h0000_1003, 32'h0,         1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage sequencer between the pipeline/control path and the word-addressed data memory.
- Data memory is word-only: writes on posedge when its write strobe is high; reads combinationally while its read strobe is high.
- This block adds byte/halfword/word loads with sign/zero extension, sub-word stores by read-modify-write, alignment fault detection and a start/busy/done handshake.

Parameters:
- MEM_WORDS, 1024, data memory depth in 32-bit words; used only by the optional range check.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; accepted only when busy=0.
- op  input  2  00 none, 01 load, 10 store, 11 reserved.
- size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- unsigned_ld  input  1  1 = zero-extend loads, 0 = sign-extend loads.
- addr  input  32  byte address.
- store_data  input  32  store value; the low byte or half is used for sub-word stores.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- fault  output  1  valid with done; 1 means the request was rejected with no memory access.
- load_data  output  32  extended load result.
- mem_read  output  1  data memory read strobe.
- mem_write  output  1  data memory write strobe.
- mem_address  output  32  word-aligned address, {req_addr[31:2],2'b00}.
- mem_write_data  output  32  word written to memory.
- mem_read_data  input  32  combinational read data from memory.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE; busy, done, fault, mem_read, mem_write = 0; load_data = 0; internal request registers and merge register = 0.
- Accept:
  - In IDLE, start=1 with op!=00 latches op, size, unsigned_ld, addr and store_data.
  - start while busy, or op=00, is ignored.
  - Inputs are don't-care after the accept edge.
- Byte lanes are little-endian:
  - byte k = bits [8k+7:8k], k = addr[1:0].
  - half h = bits [16h+15:16h], h = addr[1].
- Fault conditions, checked at accept:
  - op=11 or size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0.
- State machine: IDLE, LOAD, WRITE, RMW_READ, RMW_WRITE, DONE, ERR.
  - IDLE->ERR on a faulting request.
  - IDLE->LOAD for a load.
  - IDLE->WRITE for a word store.
  - IDLE->RMW_READ for a byte or half store.
  - LOAD: mem_read=1; at the end of the cycle, load_data <= extended lane of mem_read_data; ->DONE.
  - WRITE: mem_write=1, mem_write_data=req store_data; ->DONE.
  - RMW_READ: mem_read=1; merge register <= mem_read_data with the selected lane replaced by store_data[7:0] or [15:0]; ->RMW_WRITE.
  - RMW_WRITE: mem_write=1, mem_write_data=merge register; ->DONE.
  - DONE: done=1, fault=0; ->IDLE.
  - ERR: done=1, fault=1; mem_read and mem_write stay 0; load_data unchanged; ->IDLE.
- Strobes are combinational decodes of state.
  - mem_read and mem_write are never high in the same cycle.
  - Each is high exactly one cycle per operation.
- Latency, counted in cycles after the accept cycle:
  - done in cycle 2 for a load or word store;
  - done in cycle 3 for a sub-word store;
  - done in cycle 1 for a fault.
- The next request can be accepted in the cycle after done.
- load_data holds its value until the next successful load completes; stores and faults do not change it.
- mem_write_data is 0 outside WRITE and RMW_WRITE.
- Reset in any state, including RMW_READ, RMW_WRITE or DONE:
  - returns to IDLE at the next edge;
  - no mem_write and no done in the following cycle;
  - the pending operation is abandoned.

Optional Feature:
- Macro: LSU_RANGE_CHECK_EN.
- Defined: addr >= MEM_WORDS*4 is an additional fault condition (ERR path, no memory access).
- Undefined: no range check; the memory indexes by address[11:2], so out-of-range addresses alias onto low words.

Test Plan:
- Store word 0xDEADBEEF to 0x10, then load word from 0x10 -> each done in cycle 2; exactly one mem_write pulse with mem_address=0x10; load_data=0xDEADBEEF; fault=0.
- Store byte store_data=0x00000080 to 0x11, then signed lb 0x11, then lbu 0x11 -> store done in cycle 3 with one mem_read then one mem_write; word becomes 0xDEAD80EF; lb gives 0xFFFFFF80; lbu gives 0x00000080.
- Signed lh 0x12, then lhu 0x12 on word 0xDEAD80EF -> 0xFFFFDEAD and 0x0000DEAD; lh 0x10 -> 0xFFFF80EF.
- lw 0x13, sh 0x11 and op=11 -> each done in cycle 1 with fault=1; no mem_read or mem_write; load_data unchanged.
- Start sh 0xAAAA to 0x10, assert reset during RMW_READ -> next cycle busy=0, no mem_write ever; lw 0x10 afterwards still 0xDEAD80EF. Start asserted while busy is ignored with no extra done.
- MEM_WORDS=1024, lw 0x1000:
  - macro defined -> fault=1.
  - macro undefined -> load_data equals word 0, with mem_address=0x1000.
